// File: rtl/register_shift_unit.sv
// Purpose: WIDTH-bit shift/rotate/load register with single-step (en) and counted multi-step (start/amount) operation.
// Latency: single-step ops land on the next edge; an N-step run applies steps on N consecutive edges (first on the start edge), done follows one cycle after the final step's busy cycle.
// Backpressure: none; start/en/mode/amount are ignored while busy, and a new start is accepted in the cycle done is high.
// Ports: clk, rst_n (async active-low), en, mode[2:0], d[WIDTH-1:0], ser_in, start, amount[CNT_W-1:0]
//        -> q[WIDTH-1:0], ser_out, busy, done (all registered).
module register_shift_unit #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt, w_step_q;
  logic             r_ser, w_ser_nxt, w_step_ser;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_mode, w_mode_nxt;
  logic [2:0]       w_op;
  logic             w_multi;

  // During a run the latched mode drives the datapath; live mode is ignored.
  assign w_op    = (r_state == RUN) ? r_mode : mode;
  // Only the shift/rotate modes are repeatable; hold/load/clear run once.
  assign w_multi = (mode >= 3'b010) && (mode <= 3'b110);

  // One step of the selected operation applied to the current register.
  always_comb begin
    w_step_q   = r_q;
    w_step_ser = r_ser;
    case (w_op)
      3'b001: w_step_q = d;
      3'b010: begin
        w_step_q   = {r_q[WIDTH-2:0], ser_in};
        w_step_ser = r_q[WIDTH-1];
      end
      3'b011: begin
        w_step_q   = {ser_in, r_q[WIDTH-1:1]};
        w_step_ser = r_q[0];
      end
      3'b100: begin
        w_step_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_step_ser = r_q[WIDTH-1];
      end
      3'b101: begin
        w_step_q   = {r_q[0], r_q[WIDTH-1:1]};
        w_step_ser = r_q[0];
      end
      3'b110: begin
        w_step_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_step_ser = r_q[0];
      end
      3'b111: begin
        w_step_q   = '0;
        w_step_ser = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_ser_nxt   = r_ser;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_multi) begin
            if (amount == CNT_ZERO) begin
              w_done_nxt = 1'b1;
            end else begin
              // First step lands on the start edge; the rest are counted down in RUN.
              w_q_nxt     = w_step_q;
              w_ser_nxt   = w_step_ser;
              w_cnt_nxt   = amount - CNT_ONE;
              w_mode_nxt  = mode;
              w_busy_nxt  = 1'b1;
              w_state_nxt = RUN;
            end
          end else begin
            w_q_nxt    = w_step_q;
            w_ser_nxt  = w_step_ser;
            w_done_nxt = 1'b1;
          end
        end else if (en) begin
          w_q_nxt   = w_step_q;
          w_ser_nxt = w_step_ser;
        end
      end
      RUN: begin
        if (r_cnt != CNT_ZERO) begin
          w_q_nxt    = w_step_q;
          w_ser_nxt  = w_step_ser;
          w_cnt_nxt  = r_cnt - CNT_ONE;
          w_busy_nxt = 1'b1;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_ser  <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 3'b000;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_ser  <= w_ser_nxt;
      r_cnt  <= w_cnt_nxt;
      r_mode <= w_mode_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q       = r_q;
  assign ser_out = r_ser;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_register_shift_unit.sv
// Purpose: directed self-checking bench for register_shift_unit at WIDTH=20, CNT_W=5.
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; every wait on done is bounded by a cycle budget.
module tb_register_shift_unit;

  localparam int WIDTH = 20;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;

  register_shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .ser_in  (ser_in),
    .start   (start),
    .amount  (amount),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    start = 1'b0;
    en    = 1'b1;
    mode  = 3'b001;
    d     = val;
    tick();
    en    = 1'b0;
    mode  = 3'b000;
  endtask

  // Steps until done is seen or the budget runs out, counting busy cycles.
  task automatic run_until_done(input int limit, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      if (busy) nbusy++;
      tick();
    end
  endtask

  int nb;
  int ndone;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 3'b000;
    d       = '0;
    ser_in  = 1'b0;
    start   = 1'b0;
    amount  = '0;
    tick();
    check("rst_q",    64'(q),       64'h0);
    check("rst_ser",  64'(ser_out), 64'h0);
    check("rst_busy", 64'(busy),    64'h0);
    check("rst_done", 64'(done),    64'h0);
    rst_n = 1'b1;
    tick();

    // Single-step left shifts with a one fill.
    load(20'hABCDE);
    check("load_q", 64'(q), 64'hABCDE);
    en = 1'b1; mode = 3'b010; ser_in = 1'b1;
    tick();
    check("shl1_q",   64'(q),       64'h579BD);
    check("shl1_ser", 64'(ser_out), 64'h1);
    repeat (3) tick();
    check("shl4_q",   64'(q),       64'hBCDEF);
    check("shl4_ser", 64'(ser_out), 64'h0);
    en = 1'b0;
    tick();
    check("hold_q", 64'(q), 64'hBCDEF);

    // Multi-step logical right shift by 3.
    load(20'h80001);
    start = 1'b1; mode = 3'b011; amount = 5'd3; ser_in = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000; amount = '0;
    check("lsr_s1_q",    64'(q),       64'h40000);
    check("lsr_s1_ser",  64'(ser_out), 64'h1);
    check("lsr_s1_busy", 64'(busy),    64'h1);
    tick();
    check("lsr_s2_busy", 64'(busy), 64'h1);
    tick();
    check("lsr_s3_q",    64'(q),       64'h10000);
    check("lsr_s3_ser",  64'(ser_out), 64'h0);
    check("lsr_s3_busy", 64'(busy),    64'h1);
    check("lsr_s3_done", 64'(done),    64'h0);
    tick();
    check("lsr_done",   64'(done), 64'h1);
    check("lsr_idle",   64'(busy), 64'h0);
    check("lsr_fin_q",  64'(q),    64'h10000);
    tick();
    check("lsr_done_1cyc", 64'(done), 64'h0);

    // Arithmetic right shift past WIDTH saturates to the sign fill.
    load(20'h80000);
    start = 1'b1; mode = 3'b110; amount = 5'd25;
    tick();
    start = 1'b0; mode = 3'b000; amount = '0;
    check("asr_s1_q", 64'(q), 64'hC0000);
    run_until_done(40, nb);
    check("asr_done",  64'(done),    64'h1);
    check("asr_busy",  64'(nb),      64'd25);
    check("asr_q",     64'(q),       64'hFFFFF);
    check("asr_ser",   64'(ser_out), 64'h1);

    // Rotate left by WIDTH returns the original word.
    load(20'h12345);
    start = 1'b1; mode = 3'b100; amount = 5'd20;
    tick();
    start = 1'b0; mode = 3'b000; amount = '0;
    run_until_done(40, nb);
    check("rol_done", 64'(done),    64'h1);
    check("rol_busy", 64'(nb),      64'd20);
    check("rol_q",    64'(q),       64'h12345);
    check("rol_ser",  64'(ser_out), 64'h1);
    tick();
    check("rol_done_1cyc", 64'(done), 64'h0);

    // Start with zero amount: no run, done next cycle.
    start = 1'b1; mode = 3'b011; amount = 5'd0; ser_in = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    check("amt0_q",    64'(q),    64'h12345);
    check("amt0_busy", 64'(busy), 64'h0);
    check("amt0_done", 64'(done), 64'h1);
    tick();
    check("amt0_done_1cyc", 64'(done), 64'h0);

    // Start with one-shot modes runs once regardless of en.
    en = 1'b0; start = 1'b1; mode = 3'b111; amount = 5'd9;
    tick();
    check("st_clr_q",    64'(q),    64'h0);
    check("st_clr_done", 64'(done), 64'h1);
    mode = 3'b001; d = 20'h00F0F;
    tick();
    start = 1'b0; mode = 3'b000;
    check("st_load_q",    64'(q),    64'h00F0F);
    check("st_load_done", 64'(done), 64'h1);
    check("st_load_busy", 64'(busy), 64'h0);

    // Rotate right by 4 with junk on control inputs during the run.
    start = 1'b1; mode = 3'b101; amount = 5'd4; ser_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      en     = i[0];
      start  = 1'b1;
      mode   = i[0] ? 3'b111 : 3'b001;
      amount = 5'd7;
      d      = 20'h00000;
      if (i < 3) check($sformatf("ror_busy%0d", i), 64'(busy), 64'h1);
      tick();
    end
    check("ror_done", 64'(done),    64'h1);
    check("ror_idle", 64'(busy),    64'h0);
    check("ror_q",    64'(q),       64'hF00F0);
    check("ror_ser",  64'(ser_out), 64'h1);
    // Back-to-back start in the done cycle.
    en = 1'b0; start = 1'b1; mode = 3'b010; amount = 5'd2; ser_in = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000; amount = '0;
    check("b2b_busy", 64'(busy),    64'h1);
    check("b2b_q1",   64'(q),       64'hE01E0);
    check("b2b_ser",  64'(ser_out), 64'h1);
    tick();
    check("b2b_q2", 64'(q), 64'hC03C0);
    tick();
    check("b2b_done", 64'(done), 64'h1);

    // Reset asserted during step 2 of a run.
    load(20'h12345);
    start = 1'b1; mode = 3'b010; amount = 5'd5;
    tick();
    start = 1'b0; mode = 3'b000; amount = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_q",    64'(q),       64'h0);
    check("rstmid_busy", 64'(busy),    64'h0);
    check("rstmid_ser",  64'(ser_out), 64'h0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    check("rstmid_nodone", 64'(ndone), 64'd0);
    check("rstmid_hold_q", 64'(q),     64'h0);
    load(20'h00ABC);
    check("post_rst_load", 64'(q), 64'h00ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
